// File: rtl/kbd_cmd_pkg.sv
// Shared types for the keyboard command controller: command codes, key constants, decoder.
// Build option KBD_LOWERCASE_EN: when defined, lowercase letters decode like uppercase.
package kbd_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_STOP    = 3'd1,
        CMD_START   = 3'd2,
        CMD_BACK    = 3'd3,
        CMD_FWD     = 3'd4,
        CMD_RESTART = 3'd5
    } cmd_t;

    localparam logic [7:0] ASCII_D = 8'h44;
    localparam logic [7:0] ASCII_E = 8'h45;
    localparam logic [7:0] ASCII_B = 8'h42;
    localparam logic [7:0] ASCII_F = 8'h46;
    localparam logic [7:0] ASCII_R = 8'h52;

    function automatic cmd_t decode_key(input logic [7:0] key);
        logic [7:0] w_key;
        cmd_t       w_cmd;
        w_key = key;
`ifdef KBD_LOWERCASE_EN
        // Folding bit 5 maps 'a'..'z' onto 'A'..'Z'.
        if (key >= 8'h61 && key <= 8'h7A) begin
            w_key = key & 8'hDF;
        end
`endif
        case (w_key)
            ASCII_D: w_cmd = CMD_STOP;
            ASCII_E: w_cmd = CMD_START;
            ASCII_B: w_cmd = CMD_BACK;
            ASCII_F: w_cmd = CMD_FWD;
            ASCII_R: w_cmd = CMD_RESTART;
            default: w_cmd = CMD_NONE;
        endcase
        return w_cmd;
    endfunction

endpackage

// File: rtl/kbd_cmd_ctrl_if.sv
// Command handshake between the keyboard controller (master) and the flash/audio FSM (slave).
// A command transfers on a rising clk edge where cmd_valid && cmd_ready; cmd_valid never waits on cmd_ready.
interface kbd_cmd_ctrl_if;
    import kbd_cmd_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    cmd_t cmd_code;

    modport master (
        output cmd_valid,
        output cmd_code,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        output cmd_ready
    );

endinterface

// File: rtl/kbd_cmd_fifo.sv
// Parametrised synchronous FIFO (power-of-two DEPTH) holding queued commands.
// A push while full is accepted only when a pop happens on the same edge.
module kbd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/kbd_cmd_ctrl.sv
// Keyboard command controller: synchronise and debounce the ASCII byte, decode player commands,
// track play/direction status and queue commands for the audio FSM. Honours KBD_LOWERCASE_EN.
module kbd_cmd_ctrl
    import kbd_cmd_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            kbd,
    kbd_cmd_ctrl_if.master        cmd_if,
    output logic                  playing,
    output logic                  forward,
    output logic                  restart_pulse,
    output logic                  overflow
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [7:0] r_sync1;
    logic [7:0] r_kbd_s;
    logic [7:0] r_cnt;
    logic [7:0] r_last_acc;
    logic       r_playing;
    logic       r_forward;
    logic       r_restart;
    logic       r_overflow;

    logic [7:0] w_cnt_next;
    logic       w_accept;
    cmd_t       w_cmd;
    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;
    logic [2:0] w_dout;

    // The filter judges the sample that is entering kbd_s, so r_kbd_s is both the second
    // synchroniser stage and the filter candidate; acceptance lands STABLE-1 edges after kbd_s updates.
    always_comb begin
        w_cnt_next = 8'd1;
        if (r_sync1 == r_kbd_s) begin
            w_cnt_next = (r_cnt >= STABLE) ? STABLE : r_cnt + 8'd1;
        end
    end

    assign w_accept = (w_cnt_next == STABLE) && (r_sync1 != r_last_acc);
    assign w_cmd    = decode_key(r_sync1);
    assign w_push   = w_accept && (w_cmd != CMD_NONE);
    assign w_pop    = cmd_if.cmd_valid && cmd_if.cmd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 8'h00;
            r_kbd_s    <= 8'h00;
            r_cnt      <= 8'd0;
            r_last_acc <= 8'h00;
        end else begin
            r_sync1 <= kbd;
            r_kbd_s <= r_sync1;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_last_acc <= r_sync1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_playing  <= 1'b0;
            r_forward  <= 1'b1;
            r_restart  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_restart <= w_accept && (w_cmd == CMD_RESTART);
            if (w_accept) begin
                case (w_cmd)
                    CMD_START: r_playing <= 1'b1;
                    CMD_STOP:  r_playing <= 1'b0;
                    CMD_FWD:   r_forward <= 1'b1;
                    CMD_BACK:  r_forward <= 1'b0;
                    default:   ;
                endcase
            end
            // Status above still follows a dropped command; only the queue entry is lost.
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    kbd_cmd_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .din     (w_cmd),
        .pop     (w_pop),
        .dout    (w_dout),
        .empty   (w_empty),
        .full    (w_full)
    );

    assign cmd_if.cmd_valid = !w_empty;
    assign cmd_if.cmd_code  = w_empty ? CMD_NONE : cmd_t'(w_dout);
    assign playing          = r_playing;
    assign forward          = r_forward;
    assign restart_pulse    = r_restart;
    assign overflow         = r_overflow;

endmodule

// File: doc/kbd_cmd_ctrl.md
# kbd_cmd_ctrl

Parametrised keyboard command controller for the audio-player lab. It samples the 8-bit ASCII keyboard byte on the system clock and filters it for stability. Each new keypress is decoded against the player command set (D stop, E start, B backward, F forward, R restart). Accepted commands are queued for the flash/audio FSM, and the persistent play/direction status is maintained.

## Interface
- `STABLE_CYCLES`, default 4: consecutive clock edges a new `kbd` value must hold before acceptance; legal range 1–255.
- `QUEUE_DEPTH`, default 4: command queue entries; power of two, 2–16.
- `clk` in 1: single system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `kbd` in 8: ASCII byte from the keyboard module; asynchronous to `clk`.
- `cmd_valid` out 1: queue non-empty; `cmd_code` is valid.
- `cmd_ready` in 1: consumer accepts head entry when `cmd_valid && cmd_ready`.
- `cmd_code` out 3: head-of-queue command code, `cmd_t`.
- `playing` out 1: play state, set by start and cleared by stop.
- `forward` out 1: direction, set by forward and cleared by backward.
- `restart_pulse` out 1: one-cycle strobe on an accepted restart.
- `overflow` out 1: sticky; a command was dropped because the queue was full.

## Operation
- **Input sampling.** `kbd` passes through a 2-flop synchroniser to give `kbd_s`.
- **Stability filter.** The filter tracks `cand` and a counter.
  - If `kbd_s != cand`, load `cand = kbd_s` and set the counter to 1.
  - Otherwise the counter increments, saturating at `STABLE_CYCLES`.
  - When the counter reaches `STABLE_CYCLES` and `cand != last_acc`, the block accepts: `last_acc <= cand`.
  - Each accepted value counts as exactly one keypress. Pressing the same key again requires an intervening different stable value, for example release to 0x00.
- **Decode** of accepted values:
  - 'D' → `CMD_STOP` (1)
  - 'E' → `CMD_START` (2)
  - 'B' → `CMD_BACK` (3)
  - 'F' → `CMD_FWD` (4)
  - 'R' → `CMD_RESTART` (5)
  - Any other byte, including 0x00, is ignored: no push and no status change.
- **Status update** happens at acceptance, independent of the queue:
  - START sets `playing`; STOP clears it.
  - FWD sets `forward`; BACK clears it.
  - RESTART asserts `restart_pulse` for exactly one cycle and leaves `playing` and `forward` unchanged.
- **Queue push.** Every decoded command is pushed into a FIFO of depth `QUEUE_DEPTH`.
  - If the FIFO is full and there is no pop in the same cycle, the command is dropped and `overflow` sets. Status is still updated.
  - Full with a simultaneous pop and push: both succeed and occupancy is unchanged.
  - Empty with a push: `cmd_valid` rises the next cycle; there is no bypass.
- **Queue output.** `cmd_code` holds the head entry and is `CMD_NONE` (0) when the queue is empty.
- **Overflow clear.** `overflow` clears only on reset.
- **Reset values:**
  - `cmd_valid` 0, `cmd_code` 0, `restart_pulse` 0, `overflow` 0.
  - `playing` 0, `forward` 1.
  - `cand` 0x00, `last_acc` 0x00, counter 0, FIFO empty.
- **Reset mid-operation.** Reset discards queued commands and any in-progress filter count immediately (asynchronously).

## Timing
- **Acceptance edge.** `kbd` changes and then holds. Let `kbd_s` first show the new value after edge n; n = 2 because of the synchroniser. Acceptance occurs at edge n+STABLE_CYCLES−1.
- **Output latency.** `playing`, `forward`, `restart_pulse` and FIFO write are registered on the acceptance edge. With STABLE_CYCLES=4, that is 5 edges after the `kbd` change.
- **Glitch rejection.** Glitches shorter than `STABLE_CYCLES` synchronised cycles produce no acceptance.
- **Pop.** Pops on the edge where `cmd_valid && cmd_ready`; the next head entry appears after that edge.
- **Throughput.** Maximum one push per cycle and one pop per cycle.
- **Pulse behaviour.** `restart_pulse` never lasts longer than one cycle. A held R gives a single pulse.

## Configuration
- Macro `KBD_LOWERCASE_EN`.
  - Defined: lowercase 'd','e','b','f','r' decode identically to uppercase, by clearing bit 5 for 0x61–0x7A.
  - Undefined: only uppercase is decoded, and lowercase bytes are ignored like any other byte.
- Filter and queue behaviour are identical in both builds.

## Structure
- Package `kbd_cmd_pkg` holds:
  - `cmd_t` (3-bit enum: `CMD_NONE`, `CMD_STOP`, `CMD_START`, `CMD_BACK`, `CMD_FWD`, `CMD_RESTART`).
  - ASCII constants `ASCII_D`, `ASCII_E`, `ASCII_B`, `ASCII_F`, `ASCII_R`.
  - A `decode_key` function returning `cmd_t`, with the `KBD_LOWERCASE_EN` branch inside it.
- One sub-module: `kbd_cmd_fifo`, a parametrised synchronous FIFO.
  - Ports: `clk`, `reset_n`, `push`, `din`, `pop`, `dout`, `empty`, `full`.
  - Parameters: `DEPTH`, `WIDTH`.
- The synchroniser, stability filter and status registers stay in `kbd_cmd_ctrl`.

## Test plan
1. **Basic start.** Reset, `cmd_ready`=1, hold `kbd`=0x45 ('E') for 10 cycles. Expect `playing`=1 at edge 5; exactly one `cmd_valid` beat with `cmd_code`=2.
2. **Glitch rejection.** `kbd`=0x52 ('R') for 2 cycles, then 0x00, with STABLE_CYCLES=4. Expect no `restart_pulse` and `cmd_valid` stays 0. Then hold 'R' for 20 cycles: exactly one 1-cycle `restart_pulse`.
3. **Repeat requires release.** Sequence 'F','B','B' with no release between the two 'B's. Expect `forward` 1→1→0 and a queue of {4,3} only. Insert 0x00 between the 'B's: the queue gets a second 3.
4. **Overflow.** Hold `cmd_ready`=0 and send 5 alternating 'E'/'D' presses with QUEUE_DEPTH=4. Expect `overflow`=1 and the 4 oldest codes {2,1,2,1} in order. Final `playing` reflects the 5th press (0... the sequence E,D,E,D,E gives `playing`=1).
5. **Simultaneous pop and push on full.** Fill the queue, then assert `cmd_ready` on the acceptance edge of a new 'F'. Expect no overflow, occupancy stays 4, and 4 is the tail entry.
6. **Case handling and reset.** 'e' (0x65): `playing`=1 with `KBD_LOWERCASE_EN` defined, ignored without it. Then assert `reset_n`=0 mid-queue: all outputs return to reset values immediately, `forward`=1.
